// File: rtl/ex_mdu_ctrl_if.sv
// Handshake and data bundle between the EX stage and the multiply/divide sequencer.
interface ex_mdu_ctrl_if #(
    parameter int unsigned XLEN = 32
);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic            flush;
    logic            stall;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    // Pipeline side: issues operations and consumes the result.
    modport master (
        output start, op, A, B, flush,
        input  stall, busy, done, result
    );

    // Sequencer side.
    modport slave (
        input  start, op, A, B, flush,
        output stall, busy, done, result
    );
endinterface

// File: rtl/ex_mdu_ctrl.sv
// Multi-cycle unsigned multiply/divide sequencer for the EX stage.
// One shift-add or restoring-divide step per cycle, XLEN steps per operation.
// Datapath registers are shared: {hi, lo} is the product for multiplies and
// {remainder, quotient} for divides; opnd holds the multiplicand or divisor.
module ex_mdu_ctrl #(
    parameter int unsigned XLEN = 32
) (
    input logic           clk,
    input logic           rst,
    ex_mdu_ctrl_if.slave  bus
);
    localparam int unsigned CntW = $clog2(XLEN);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [1:0]        op_q, op_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              accept;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            op_q     <= '0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            opnd_q   <= opnd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            result_q <= result_d;
        end
    end

    // Next-state, iteration step and result loading.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        opnd_d   = opnd_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        result_d = result_q;

        // Carry out of the add becomes the MSB after the right shift.
        mul_sum   = {1'b0, hi_q} + {1'b0, opnd_q};
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd_q};

        accept = bus.start & ~bus.flush & ((state_q == StIdle) | (state_q == StDone));

        unique case (state_q)
            StIdle, StDone: begin
                if (accept) begin
                    op_d  = bus.op;
                    cnt_d = CntW'(XLEN - 1);
                    hi_d  = '0;
                    if (bus.op[1]) begin
                        opnd_d = bus.B;
                        lo_d   = bus.A;
                    end else begin
                        opnd_d = bus.A;
                        lo_d   = bus.B;
                    end
                    // Divide by zero resolves at acceptance without iterating.
                    if (bus.op[1] && (bus.B == '0)) begin
                        state_d  = StDone;
                        result_d = bus.op[0] ? bus.A : '1;
                    end else begin
                        state_d = StBusy;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            StBusy: begin
                if (bus.flush) begin
                    state_d = StIdle;
                end else begin
                    if (!op_q[1]) begin
                        if (lo_q[0]) begin
                            {hi_d, lo_d} = {mul_sum, lo_q[XLEN-1:1]};
                        end else begin
                            {hi_d, lo_d} = {1'b0, hi_q, lo_q[XLEN-1:1]};
                        end
                    end else begin
                        if (!div_diff[XLEN]) begin
                            hi_d = div_diff[XLEN-1:0];
                            lo_d = {lo_q[XLEN-2:0], 1'b1};
                        end else begin
                            hi_d = div_shift[XLEN-1:0];
                            lo_d = {lo_q[XLEN-2:0], 1'b0};
                        end
                    end
                    cnt_d = cnt_q - CntW'(1);
                    if (cnt_q == '0) begin
                        state_d = StDone;
                        // MULHU and REMU take the upper register, MUL and DIVU the lower.
                        result_d = op_q[0] ? hi_d : lo_d;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output decode.
    always_comb begin
        bus.stall  = accept | (state_q == StBusy);
        bus.busy   = (state_q == StBusy);
        bus.done   = (state_q == StDone);
        bus.result = result_q;
    end
endmodule
